// File: rtl/avalon_mm_arbiter.sv
// avalon_mm_arbiter: two-master round-robin Avalon-MM arbiter with lock holding and lock watchdog
module avalon_mm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] M0_ADDRESS,
  input  logic [DATA_W-1:0] M0_WRITEDATA,
  input  logic              M0_READ,
  input  logic              M0_WRITE,
  input  logic              M0_LOCK,
  input  logic              M0_BEGINTRANSFER,
  output logic              M0_WAITREQUEST,
  output logic [DATA_W-1:0] M0_READDATA,
  input  logic [ADDR_W-1:0] M1_ADDRESS,
  input  logic [DATA_W-1:0] M1_WRITEDATA,
  input  logic              M1_READ,
  input  logic              M1_WRITE,
  input  logic              M1_LOCK,
  input  logic              M1_BEGINTRANSFER,
  output logic              M1_WAITREQUEST,
  output logic [DATA_W-1:0] M1_READDATA,
  output logic [ADDR_W-1:0] S_ADDRESS,
  output logic [DATA_W-1:0] S_WRITEDATA,
  output logic              S_READ,
  output logic              S_WRITE,
  output logic              S_LOCK,
  output logic              S_BEGINTRANSFER,
  input  logic              S_WAITREQUEST,
  input  logic [DATA_W-1:0] S_READDATA,
  output logic [1:0]        GRANT,
  output logic              LOCK_ERR
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam int WD_W = $clog2(LOCK_TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(LOCK_TIMEOUT - 1);
  logic [1:0] state, state_nx;
  logic [WD_W-1:0] wd;
  logic req0, req1, own0, own1, req_o, lock_o, done, wd_hit, rr_last, started, lock_err;
  logic unused;
  assign unused = ^{M0_BEGINTRANSFER, M1_BEGINTRANSFER};
  assign req0 = M0_READ | M0_WRITE;
  assign req1 = M1_READ | M1_WRITE;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign req_o = own0 ? req0 : own1 ? req1 : 1'b0;
  assign lock_o = own0 ? M0_LOCK : own1 ? M1_LOCK : 1'b0;
  assign done = req_o & ~S_WAITREQUEST;
  assign wd_hit = ~req_o & lock_o & (wd == WD_MAX);
  // next owner: round-robin from idle, hold under lock, release on completion, idle or watchdog
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = (req0 & (~req1 | rr_last)) ? OWN0 : req1 ? OWN1 : IDLE;
    else if (done)
      state_nx = lock_o ? state : IDLE;
    else if (~req_o & (~lock_o | wd_hit))
      state_nx = IDLE;
  end
  // owner, round-robin history, transfer-start tracking and lock watchdog
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      wd       <= '0;
      started  <= 1'b0;
      lock_err <= 1'b0;
    end else begin
      state    <= state_nx;
      started  <= req_o & ~done;
      wd       <= (req_o | ~lock_o | wd_hit) ? '0 : wd + 1'b1;
      lock_err <= wd_hit;
      if (done | wd_hit) rr_last <= own1;
    end
  end
  assign S_ADDRESS       = own0 ? M0_ADDRESS : own1 ? M1_ADDRESS : '0;
  assign S_WRITEDATA     = own0 ? M0_WRITEDATA : own1 ? M1_WRITEDATA : '0;
  assign S_READ          = own0 ? M0_READ : own1 ? M1_READ : 1'b0;
  assign S_WRITE         = own0 ? M0_WRITE & ~M0_READ : own1 ? M1_WRITE & ~M1_READ : 1'b0;
  assign S_LOCK          = lock_o;
  assign S_BEGINTRANSFER = req_o & ~started;
  assign M0_WAITREQUEST  = own0 ? S_WAITREQUEST : 1'b1;
  assign M1_WAITREQUEST  = own1 ? S_WAITREQUEST : 1'b1;
  assign M0_READDATA     = own0 ? S_READDATA : '0;
  assign M1_READDATA     = own1 ? S_READDATA : '0;
  assign GRANT           = {own1, own0};
  assign LOCK_ERR        = lock_err;
endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// tb_avalon_mm_arbiter: scoreboard bench for the two-master Avalon-MM arbiter
module tb_avalon_mm_arbiter;
  typedef struct {logic [1:0] g; logic [31:0] a; logic [31:0] d; logic r; logic w; logic l;} beg_t;
  typedef struct {logic [1:0] g; logic [31:0] r0; logic [31:0] r1;} cmp_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [31:0] M0_ADDRESS = '0, M0_WRITEDATA = '0, M1_ADDRESS = '0, M1_WRITEDATA = '0;
  logic M0_READ = 1'b0, M0_WRITE = 1'b0, M0_LOCK = 1'b0, M0_BEGINTRANSFER = 1'b0;
  logic M1_READ = 1'b0, M1_WRITE = 1'b0, M1_LOCK = 1'b0, M1_BEGINTRANSFER = 1'b0;
  logic M0_WAITREQUEST, M1_WAITREQUEST;
  logic [31:0] M0_READDATA, M1_READDATA, S_ADDRESS, S_WRITEDATA, S_READDATA;
  logic S_READ, S_WRITE, S_LOCK, S_BEGINTRANSFER, S_WAITREQUEST, LOCK_ERR;
  logic [1:0] GRANT;
  int total = 0;
  int bad = 0;
  int ws = 1;
  int wcnt;
  beg_t beg_q[$];
  cmp_t cmp_q[$];
  bit err_q[$];
  beg_t b;
  cmp_t c;
  bit e;

  avalon_mm_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .M0_ADDRESS(M0_ADDRESS), .M0_WRITEDATA(M0_WRITEDATA), .M0_READ(M0_READ), .M0_WRITE(M0_WRITE),
    .M0_LOCK(M0_LOCK), .M0_BEGINTRANSFER(M0_BEGINTRANSFER), .M0_WAITREQUEST(M0_WAITREQUEST),
    .M0_READDATA(M0_READDATA),
    .M1_ADDRESS(M1_ADDRESS), .M1_WRITEDATA(M1_WRITEDATA), .M1_READ(M1_READ), .M1_WRITE(M1_WRITE),
    .M1_LOCK(M1_LOCK), .M1_BEGINTRANSFER(M1_BEGINTRANSFER), .M1_WAITREQUEST(M1_WAITREQUEST),
    .M1_READDATA(M1_READDATA),
    .S_ADDRESS(S_ADDRESS), .S_WRITEDATA(S_WRITEDATA), .S_READ(S_READ), .S_WRITE(S_WRITE),
    .S_LOCK(S_LOCK), .S_BEGINTRANSFER(S_BEGINTRANSFER), .S_WAITREQUEST(S_WAITREQUEST),
    .S_READDATA(S_READDATA), .GRANT(GRANT), .LOCK_ERR(LOCK_ERR)
  );

  always #5 CLK = ~CLK;

  // slave model: ws wait cycles per transfer, read data derived from the address
  always @(posedge CLK or posedge RST)
    if (RST) wcnt <= 0;
    else wcnt <= ((S_READ | S_WRITE) && S_WAITREQUEST) ? wcnt + 1 : 0;
  assign S_WAITREQUEST = (S_READ | S_WRITE) ? (wcnt < ws) : 1'b1;
  assign S_READDATA = S_ADDRESS ^ 32'hDEADBEEF;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // monitor: transfer starts, completions, watchdog pulses and non-owner masking
  always @(negedge CLK) begin
    if (S_BEGINTRANSFER) begin
      chk("beg_expected", 32'(beg_q.size() != 0), 1);
      if (beg_q.size() != 0) begin
        b = beg_q.pop_front();
        chk("beg_grant", 32'(GRANT), 32'(b.g));
        chk("beg_addr", S_ADDRESS, b.a);
        chk("beg_wdata", S_WRITEDATA, b.d);
        chk("beg_read", 32'(S_READ), 32'(b.r));
        chk("beg_write", 32'(S_WRITE), 32'(b.w));
        chk("beg_lock", 32'(S_LOCK), 32'(b.l));
      end
    end
    if (GRANT != 2'b00 && (S_READ | S_WRITE) && !(GRANT[0] ? M0_WAITREQUEST : M1_WAITREQUEST)) begin
      chk("cmp_expected", 32'(cmp_q.size() != 0), 1);
      if (cmp_q.size() != 0) begin
        c = cmp_q.pop_front();
        chk("cmp_grant", 32'(GRANT), 32'(c.g));
        chk("cmp_m0_rdata", M0_READDATA, c.r0);
        chk("cmp_m1_rdata", M1_READDATA, c.r1);
      end
    end
    if (LOCK_ERR) begin
      chk("lock_err_expected", 32'(err_q.size() != 0), 1);
      if (err_q.size() != 0) e = err_q.pop_front();
    end
    if (!GRANT[0]) begin
      chk("m0_masked_wreq", 32'(M0_WAITREQUEST), 1);
      chk("m0_masked_rdata", M0_READDATA, 0);
    end
    if (!GRANT[1]) begin
      chk("m1_masked_wreq", 32'(M1_WAITREQUEST), 1);
      chk("m1_masked_rdata", M1_READDATA, 0);
    end
  end

  task automatic drive(input bit m, input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr, input logic lk);
    if (m) begin
      M1_ADDRESS = a; M1_WRITEDATA = d; M1_READ = rd; M1_WRITE = wr; M1_LOCK = lk;
    end else begin
      M0_ADDRESS = a; M0_WRITEDATA = d; M0_READ = rd; M0_WRITE = wr; M0_LOCK = lk;
    end
  endtask

  task automatic xfer(input bit m, input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr, input logic lk, input bit hold);
    int n = 0;
    drive(m, a, d, rd, wr, lk);
    do begin
      @(negedge CLK);
      n++;
    end while ((m ? M1_WAITREQUEST : M0_WAITREQUEST) && n < 300);
    chk(m ? "m1_xfer_done" : "m0_xfer_done", 32'(n < 300), 1);
    @(posedge CLK);
    #1;
    if (!hold) drive(m, a, d, 1'b0, 1'b0, lk);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    @(negedge CLK);
    chk("rst_s_addr", S_ADDRESS, 0);
    chk("rst_s_wdata", S_WRITEDATA, 0);
    chk("rst_s_ctrl", 32'({S_READ, S_WRITE, S_LOCK, S_BEGINTRANSFER}), 0);
    chk("rst_m_wreq", 32'({M0_WAITREQUEST, M1_WAITREQUEST}), 32'h3);
    chk("rst_grant", 32'(GRANT), 0);
    chk("rst_lock_err", 32'(LOCK_ERR), 0);
    RST = 1'b0;
    // single M1 write, two slave wait cycles
    ws = 2;
    beg_q.push_back('{2'b10, 32'h0C, 32'hA5, 1'b0, 1'b1, 1'b0});
    cmp_q.push_back('{2'b10, 32'h0, 32'hDEADBEE3});
    @(posedge CLK);
    #1;
    drive(1'b1, 32'h0C, 32'hA5, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    chk("t1_arb_swrite", 32'(S_WRITE), 0);
    chk("t1_arb_grant", 32'(GRANT), 0);
    @(negedge CLK);
    chk("t1_swrite", 32'(S_WRITE), 1);
    chk("t1_grant", 32'(GRANT), 32'h2);
    chk("t1_wreq0", 32'(M1_WAITREQUEST), 1);
    @(negedge CLK);
    chk("t1_wreq1", 32'(M1_WAITREQUEST), 1);
    chk("t1_no_begin", 32'(S_BEGINTRANSFER), 0);
    @(negedge CLK);
    chk("t1_wreq2", 32'(M1_WAITREQUEST), 0);
    @(posedge CLK);
    #1;
    drive(1'b1, 32'h0C, 32'hA5, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("t1_idle_grant", 32'(GRANT), 0);
    chk("t1_idle_swrite", 32'(S_WRITE), 0);
    // four simultaneous ties after reset; last one has READ and WRITE both high on M0
    do_reset();
    ws = 1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      logic both;
      both = (i == 3);
      beg_q.push_back('{2'b01, 32'h00, 32'h11, 1'b1, 1'b0, 1'b0});
      cmp_q.push_back('{2'b01, 32'hDEADBEEF, 32'h0});
      beg_q.push_back('{2'b10, 32'h08, 32'h22, 1'b0, 1'b1, 1'b0});
      cmp_q.push_back('{2'b10, 32'h0, 32'hDEADBEE7});
      fork
        xfer(1'b0, 32'h00, 32'h11, 1'b1, both, 1'b0, 1'b0);
        xfer(1'b1, 32'h08, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0);
      join
    end
    // locked M1 burst of three reads while M0 waits
    beg_q.push_back('{2'b10, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1});
    beg_q.push_back('{2'b10, 32'h14, 32'h0, 1'b1, 1'b0, 1'b1});
    beg_q.push_back('{2'b10, 32'h18, 32'h0, 1'b1, 1'b0, 1'b1});
    beg_q.push_back('{2'b01, 32'h20, 32'h55, 1'b0, 1'b1, 1'b0});
    cmp_q.push_back('{2'b10, 32'h0, 32'hDEADBEFF});
    cmp_q.push_back('{2'b10, 32'h0, 32'hDEADBEFB});
    cmp_q.push_back('{2'b10, 32'h0, 32'hDEADBEF7});
    cmp_q.push_back('{2'b01, 32'hDEADBECF, 32'h0});
    fork
      begin
        xfer(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        xfer(1'b1, 32'h14, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        xfer(1'b1, 32'h18, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        M1_LOCK = 1'b0;
      end
      begin
        @(posedge CLK);
        #1;
        xfer(1'b0, 32'h20, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0);
      end
    join
    // watchdog release of an idle locked M0 with M1 pending
    beg_q.push_back('{2'b01, 32'h30, 32'h77, 1'b0, 1'b1, 1'b1});
    beg_q.push_back('{2'b10, 32'h34, 32'h0, 1'b1, 1'b0, 1'b0});
    cmp_q.push_back('{2'b01, 32'hDEADBEDF, 32'h0});
    cmp_q.push_back('{2'b10, 32'h0, 32'hDEADBEDB});
    err_q.push_back(1'b1);
    fork
      begin
        xfer(1'b0, 32'h30, 32'h77, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
          @(negedge CLK);
          chk("wd_hold_grant", 32'(GRANT), 32'h1);
          chk("wd_hold_err", 32'(LOCK_ERR), 0);
        end
        @(negedge CLK);
        chk("wd_release_grant", 32'(GRANT), 0);
        chk("wd_release_err", 32'(LOCK_ERR), 1);
        @(negedge CLK);
        chk("wd_next_grant", 32'(GRANT), 32'h2);
        chk("wd_err_pulse", 32'(LOCK_ERR), 0);
        M0_LOCK = 1'b0;
      end
      begin
        @(posedge CLK);
        #1;
        xfer(1'b1, 32'h34, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    join
    // reset while an M1 write is stalled
    ws = 100;
    beg_q.push_back('{2'b10, 32'h40, 32'h99, 1'b0, 1'b1, 1'b0});
    @(posedge CLK);
    #1;
    drive(1'b1, 32'h40, 32'h99, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    chk("t6_swrite", 32'(S_WRITE), 1);
    chk("t6_grant", 32'(GRANT), 32'h2);
    #2;
    RST = 1'b1;
    #1;
    chk("t6_rst_swrite", 32'(S_WRITE), 0);
    chk("t6_rst_grant", 32'(GRANT), 0);
    chk("t6_rst_wreq", 32'(M1_WAITREQUEST), 1);
    chk("t6_rst_saddr", S_ADDRESS, 0);
    drive(1'b1, 32'h40, 32'h99, 1'b0, 1'b0, 1'b0);
    ws = 1;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    beg_q.push_back('{2'b01, 32'h44, 32'h0, 1'b1, 1'b0, 1'b0});
    beg_q.push_back('{2'b10, 32'h48, 32'h66, 1'b0, 1'b1, 1'b0});
    cmp_q.push_back('{2'b01, 32'hDEADBEAB, 32'h0});
    cmp_q.push_back('{2'b10, 32'h0, 32'hDEADBEA7});
    fork
      xfer(1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      xfer(1'b1, 32'h48, 32'h66, 1'b0, 1'b1, 1'b0, 1'b0);
    join
    repeat (3) @(negedge CLK);
    chk("end_beg_q_empty", 32'(beg_q.size()), 0);
    chk("end_cmp_q_empty", 32'(cmp_q.size()), 0);
    chk("end_err_q_empty", 32'(err_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
